// File: rtl/mul4_arbiter.sv
// ---------------------------------------------------------------------------------------------
// mul4_arbiter
//   Shares one 4x4 unsigned combinational multiplier among four requesters. A round-robin
//   pointer picks the next requester in IDLE. The block captures that requester's operands and
//   spends MUL_LAT cycles in MUL. It then holds the product in RSP until the consumer accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [3:0]  per-requester request pending
//   req_ready  [3:0]  one-hot acceptance strobe (combinational, IDLE only)
//   req_a      [15:0] packed multiplicands, requester i on [4i+3:4i]
//   req_b      [15:0] packed multipliers, same packing
//   rsp_valid         result presented (RSP state)
//   rsp_ready         consumer accepts result
//   rsp_id     [1:0]  owner of rsp_y
//   rsp_y      [7:0]  unsigned product
//   busy              high in MUL and RSP
//
// Also contains multiplier_4bit, the shared 4x4 combinational multiplier.
// ---------------------------------------------------------------------------------------------

module multiplier_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    // Shift-and-add over the four multiplier bits; 8 bits holds 15*15 without overflow.
    always_comb begin
        p_o = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (b_i[i]) begin
                p_o = p_o + ({4'd0, a_i} << i);
            end
        end
    end

endmodule

module mul4_arbiter #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_id,
    output logic [7:0]  rsp_y,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StRsp
    } state_e;

    // MUL_LAT is limited to 1..8, so the cycle counter fits in three bits.
    localparam logic [2:0] CntInit = 3'(MUL_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic [1:0]  id_q, id_d;
    logic [1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]  rsp_y_q, rsp_y_d;

    logic        grant_vld;
    logic [3:0]  rot;
    logic [1:0]  off;
    logic [1:0]  grant_idx;
    logic        accept;
    logic        mul_done;
    logic        rsp_hs;
    logic [7:0]  prod;

    // ---------------------------------------------------------------------------------------
    // Round-robin pick: rotate req_valid so ptr_q sits at bit 0, then take the lowest set bit.
    // ---------------------------------------------------------------------------------------
    always_comb begin
        unique case (ptr_q)
            2'd0:    rot = req_valid;
            2'd1:    rot = {req_valid[0], req_valid[3:1]};
            2'd2:    rot = {req_valid[1:0], req_valid[3:2]};
            default: rot = {req_valid[2:0], req_valid[3]};
        endcase

        if (rot[0]) begin
            off = 2'd0;
        end else if (rot[1]) begin
            off = 2'd1;
        end else if (rot[2]) begin
            off = 2'd2;
        end else begin
            off = 2'd3;
        end

        grant_vld = |req_valid;
        grant_idx = ptr_q + off;  // wraps 3->0 naturally in two bits
    end

    assign accept   = (state_q == StIdle) && grant_vld;
    assign mul_done = (state_q == StMul) && (cnt_q == 3'd0);
    assign rsp_hs   = (state_q == StRsp) && rsp_ready;

    multiplier_4bit u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod)
    );

    // ---------------------------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    state_d = StMul;
                end
            end
            StMul: begin
                if (cnt_q == 3'd0) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------------------------
    always_comb begin
        req_ready = 4'b0000;
        // Gated by rst_n so no requester sees an acceptance while reset is held.
        if (accept && rst_n) begin
            req_ready[grant_idx] = 1'b1;
        end
        rsp_valid = (state_q == StRsp);
        busy      = (state_q != StIdle);
        rsp_id    = rsp_id_q;
        rsp_y     = rsp_y_q;
    end

    // ---------------------------------------------------------------------------------------
    // Datapath next state
    // ---------------------------------------------------------------------------------------
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        rsp_id_d = rsp_id_q;
        rsp_y_d  = rsp_y_q;

        if (accept) begin
            // Operands are frozen here; later requester activity cannot disturb the operation.
            a_d   = req_a[{grant_idx, 2'b00} +: 4];
            b_d   = req_b[{grant_idx, 2'b00} +: 4];
            id_d  = grant_idx;
            cnt_d = CntInit;
        end

        if (state_q == StMul && cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end

        if (mul_done) begin
            rsp_y_d  = prod;
            rsp_id_d = id_q;
        end

        if (rsp_hs) begin
            ptr_d = id_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= 2'd0;
            cnt_q    <= 3'd0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            id_q     <= 2'd0;
            rsp_id_q <= 2'd0;
            rsp_y_q  <= 8'd0;
        end else begin
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            rsp_id_q <= rsp_id_d;
            rsp_y_q  <= rsp_y_d;
        end
    end

endmodule

// File: tb/tb_mul4_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_mul4_arbiter
//   Directed self-checking bench for mul4_arbiter. Two instances: dut (MUL_LAT=1) and
//   dut4 (MUL_LAT=4). Inputs change 1 ns after the rising edge and are checked 1 ns later.
// ---------------------------------------------------------------------------------------------

module tb_mul4_arbiter;

    logic        clk;
    logic        rst_n;

    logic [3:0]  req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_ready, busy;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_y;

    logic [3:0]  req_valid4, req_ready4;
    logic [15:0] req_a4, req_b4;
    logic        rsp_valid4, rsp_ready4, busy4;
    logic [1:0]  rsp_id4;
    logic [7:0]  rsp_y4;

    int checks;
    int errors;

    mul4_arbiter #(.MUL_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy)
    );

    mul4_arbiter #(.MUL_LAT(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid4),
        .req_ready (req_ready4),
        .req_a     (req_a4),
        .req_b     (req_b4),
        .rsp_valid (rsp_valid4),
        .rsp_ready (rsp_ready4),
        .rsp_id    (rsp_id4),
        .rsp_y     (rsp_y4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Round-robin test operands: a = 3,6,9,12 and b = 5,7,11,15 -> products 15,42,99,180.
    logic [7:0] rr_y [4];
    logic [3:0] av, bv;

    initial begin
        checks = 0;
        errors = 0;
        rr_y[0] = 8'd15; rr_y[1] = 8'd42; rr_y[2] = 8'd99; rr_y[3] = 8'd180;

        rst_n      = 1'b0;
        req_valid  = 4'b0000; req_a  = 16'h0; req_b  = 16'h0; rsp_ready  = 1'b0;
        req_valid4 = 4'b0000; req_a4 = 16'h0; req_b4 = 16'h0; rsp_ready4 = 1'b0;

        // Reset state, with requests pending that must not be acknowledged.
        tick(); tick();
        req_valid = 4'b1111;
        settle();
        chk("rst_req_ready", 16'(req_ready), 16'h0);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_rsp_id",    16'(rsp_id), 16'h0);
        chk("rst_rsp_y",     16'(rsp_y), 16'h0);
        chk("rst_busy",      16'(busy), 16'h0);

        // Single request from requester 0: 7*9=63, response two cycles after acceptance.
        tick();
        rst_n = 1'b1;
        req_valid = 4'b0001; req_a = 16'h0007; req_b = 16'h0009;
        settle();
        chk("single_ready_T", 16'(req_ready), 16'h1);
        tick();
        req_valid = 4'b0000; req_a = 16'h000F;
        settle();
        chk("single_mul_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("single_mul_busy", 16'(busy), 16'h1);
        tick(); settle();
        chk("single_rsp_valid_T2", 16'(rsp_valid), 16'h1);
        chk("single_rsp_y", 16'(rsp_y), 16'd63);
        chk("single_rsp_id", 16'(rsp_id), 16'd0);
        chk("single_rsp_req_ready", 16'(req_ready), 16'h0);
        rsp_ready = 1'b1;
        tick(); settle();
        chk("single_back_idle", 16'(rsp_valid), 16'h0);
        chk("single_idle_busy", 16'(busy), 16'h0);

        // All four requesting, ptr=0 after reset: grants 0,1,2,3,0, one result per 3 cycles.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1111; req_a = 16'hC963; req_b = 16'hFB75; rsp_ready = 1'b1;
        for (int op = 0; op < 5; op++) begin
            settle();
            chk("rr_grant", 16'(req_ready), 16'(4'b0001 << (op % 4)));
            tick(); settle();
            chk("rr_mul_rsp_valid", 16'(rsp_valid), 16'h0);
            tick(); settle();
            chk("rr_rsp_valid", 16'(rsp_valid), 16'h1);
            chk("rr_rsp_y", 16'(rsp_y), 16'(rr_y[op % 4]));
            chk("rr_rsp_id", 16'(rsp_id), 16'(op % 4));
            tick();
        end

        // Backpressure: ptr=1, only requester 2 asks (13*11=143); operands change in flight.
        req_valid = 4'b0100; req_a = 16'h0D00; req_b = 16'h0B00; rsp_ready = 1'b0;
        settle();
        chk("bp_grant", 16'(req_ready), 16'h4);
        tick();
        req_valid = 4'b1111; req_a = 16'hFFFF; req_b = 16'h0000;
        tick(); settle();
        for (int i = 0; i < 6; i++) begin
            chk("bp_rsp_valid", 16'(rsp_valid), 16'h1);
            chk("bp_rsp_y", 16'(rsp_y), 16'd143);
            chk("bp_rsp_id", 16'(rsp_id), 16'd2);
            chk("bp_req_ready", 16'(req_ready), 16'h0);
            if (i < 5) begin
                tick(); settle();
            end
        end
        rsp_ready = 1'b1;
        tick(); settle();
        chk("bp_after_hs", 16'(rsp_valid), 16'h0);

        // All 256 operand pairs from requester 2; b is scrambled after capture.
        req_valid = 4'b0100;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                av = 4'(a); bv = 4'(b);
                req_a = {4'h0, av, 8'h00};
                req_b = {4'h0, bv, 8'h00};
                settle();
                chk("sweep_grant", 16'(req_ready), 16'h4);
                tick();
                req_b = {4'h0, ~bv, 8'h00};
                tick(); settle();
                chk("sweep_rsp_y", 16'(rsp_y), 16'(a * b));
                chk("sweep_rsp_id", 16'(rsp_id), 16'd2);
                tick();
            end
        end

        // MUL_LAT=4 instance: requester 1, 5*6=30, rsp_valid first high at T+5.
        req_valid4 = 4'b0010; req_a4 = 16'h0050; req_b4 = 16'h0060;
        settle();
        chk("lat4_grant", 16'(req_ready4), 16'h2);
        tick();
        req_valid4 = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk("lat4_wait_rsp_valid", 16'(rsp_valid4), 16'h0);
            chk("lat4_wait_busy", 16'(busy4), 16'h1);
            tick();
        end
        settle();
        chk("lat4_rsp_valid_T5", 16'(rsp_valid4), 16'h1);
        chk("lat4_rsp_y", 16'(rsp_y4), 16'd30);
        chk("lat4_rsp_id", 16'(rsp_id4), 16'd1);
        rsp_ready4 = 1'b1;
        tick();

        // Mid-MUL reset on the MUL_LAT=4 instance (15*15 from requester 3 is aborted).
        req_valid4 = 4'b1000; req_a4 = 16'hF000; req_b4 = 16'hF000;
        settle();
        chk("abort_grant", 16'(req_ready4), 16'h8);
        tick(); tick(); settle();
        chk("abort_in_mul", 16'(busy4), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 16'(busy4), 16'h0);
        chk("abort_rsp_valid", 16'(rsp_valid4), 16'h0);
        chk("abort_rsp_y", 16'(rsp_y4), 16'h0);
        chk("abort_rsp_id", 16'(rsp_id4), 16'h0);
        chk("abort_req_ready", 16'(req_ready4), 16'h0);
        chk("abort_dut1_busy", 16'(busy), 16'h0);
        chk("abort_dut1_rsp_y", 16'(rsp_y), 16'h0);
        chk("abort_dut1_req_ready", 16'(req_ready), 16'h0);
        req_valid4 = 4'b0000;
        req_valid  = 4'b0000;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("abort_no_rsp", 16'(rsp_valid4), 16'h0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul4_arbiter.md
MUL4_ARBITER -- requirements
Module: mul4_arbiter

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Parameter: MUL_LAT, default 1, number of cycles spent in MUL per operation; legal range 1..8.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req_valid  input  4  requester i has an operand pair pending.
REQ-006 Port: req_ready  output  4  one-hot acceptance strobe to requester i.
REQ-007 Port: req_a  input  16  packed multiplicands; requester i drives bits [4i+3:4i].
REQ-008 Port: req_b  input  16  packed multipliers; same packing as req_a.
REQ-009 Port: rsp_valid  output  1  a result is presented.
REQ-010 Port: rsp_ready  input  1  consumer accepts the result.
REQ-011 Port: rsp_id  output  2  index of the requester that owns rsp_y.
REQ-012 Port: rsp_y  output  8  unsigned product.
REQ-013 Port: busy  output  1  high in MUL and RSP states.

Function
REQ-014 The block SHALL time-share exactly one instance of the existing 4x4 combinational multiplier (multiplier_4bit) among 4 requesters.
REQ-015 The FSM SHALL have three states: IDLE, MUL and RSP.
REQ-016 In IDLE with any req_valid set, the FSM SHALL grant requester g, defined as the first set bit searching upward from pointer ptr with wrap 3->0.
REQ-017 In that same cycle, req_ready[g] SHALL be asserted combinationally, req_a/req_b slice g and id g SHALL be captured, a counter SHALL load MUL_LAT-1, and the FSM SHALL go to MUL.
REQ-018 req_ready SHALL be 0 in MUL and RSP, in IDLE when req_valid==0, and whenever rst_n is low.
REQ-019 In MUL, the counter SHALL decrement each cycle.
REQ-020 On the MUL cycle with counter==0, rsp_y SHALL load the multiplier output for the captured operands, rsp_id SHALL load g, and the FSM SHALL go to RSP.
REQ-021 In RSP, rsp_valid SHALL be 1, and rsp_y and rsp_id SHALL be held stable until rsp_ready is sampled high.
REQ-022 On the RSP handshake, the FSM SHALL go to IDLE and ptr SHALL become (g+1) mod 4.
REQ-023 rsp_valid SHALL be 0 in IDLE and MUL.
REQ-024 Latency: with acceptance in cycle T, rsp_valid SHALL first be high in cycle T+MUL_LAT+1.
REQ-025 With rsp_ready held high, the block SHALL sustain one operation per MUL_LAT+2 cycles.
REQ-026 If rsp_ready is already high in the first RSP cycle, the handshake SHALL complete in that cycle.
REQ-027 Arithmetic: rsp_y SHALL equal a*b unsigned; maximum 15*15=225, no overflow, no truncation.
REQ-028 Once operands are captured, changes to req_valid/req_a/req_b SHALL NOT affect the operation in flight.
REQ-029 A requester that keeps req_valid high after acceptance SHALL be treated as a new request, arbitrated normally in the next IDLE.
REQ-030 With req_valid==0 in IDLE, the FSM SHALL remain in IDLE and ptr SHALL be unchanged.
REQ-031 With all four requesters asserting continuously, grants SHALL rotate g, g+1, g+2, g+3 (mod 4); no requester waits more than 3 other operations.

Reset
REQ-032 While rst_n is low: state IDLE, ptr 0, counter 0, rsp_valid 0, rsp_id 0, rsp_y 0, busy 0, req_ready 0.
REQ-033 Reset asserted mid-operation (MUL or RSP) SHALL discard the operation: no response is produced and no requester is re-acknowledged.
REQ-034 After rst_n deasserts, the first acceptance SHALL occur no earlier than the first rising clk edge following deassertion.

Verification
REQ-035 Reset then single request (MUL_LAT=1): req_valid=0001, a0=7, b0=9 -> req_ready=0001 in cycle T; rsp_valid high at T+2 with rsp_y=63, rsp_id=0.
REQ-036 All four requesting continuously, ptr=0 at start, rsp_ready=1 -> grant order 0,1,2,3,0; one result every 3 cycles; each result matches its requester's operands.
REQ-037 Backpressure: rsp_ready held 0 for 5 cycles in RSP -> rsp_valid, rsp_y and rsp_id stable throughout; req_ready stays 0000; handshake on the first rsp_ready=1.
REQ-038 Boundary operands over all 256 a/b pairs from requester 2 -> every rsp_y equals a*b, including 15*15=225 and 0*15=0.
REQ-039 MUL_LAT=4: acceptance at T -> rsp_valid first high at T+5.
REQ-040 Mid-MUL reset: rst_n pulsed low during MUL -> all outputs return to their reset values immediately, and no rsp_valid is produced for the aborted operation.
